adder4_operand_loader: RTL and testbench
========================================

# adder4_operand_loader

Board-facing input stage that sits directly upstream of the 4-bit ripple adder. It debounces a single push-button, steps through a three-state sequence that captures operand A and then operand B from four slide switches, and drives both operands to the adder. It registers the adder's 5-bit sum for display and holds the result until the next button press.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive clock cycles the synchronized button must differ from its debounced value before that value flips. Minimum 1. Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sw` input 4: raw operand switches. Treated as quasi-static and not synchronized.
- `btn` input 1: raw, asynchronous, bouncing push-button, active-high.
- `sum_in` input 5: sum returned by the adder. Combinational function of `a_out` and `b_out`.
- `a_out` output 4: registered operand A to the adder.
- `b_out` output 4: registered operand B to the adder.
- `result` output 5: registered sum.
- `result_valid` output 1: `result` holds the sum of the current `a_out` and `b_out`.
- `overflow` output 1: equals `result[4]` and is qualified by `result_valid`.
- `state` output 2: current state, encoded LOAD_A=0, LOAD_B=1, SHOW=2. The value 3 is unused.

## Operation
- **Reset.** On a `rst` edge: `state`=LOAD_A, `a_out`=0, `b_out`=0, `result`=0, `result_valid`=0, `overflow`=0, sync flops=0, debounced level=0, debounce counter=0. Reset mid-sequence abandons any partially entered operands.
- **Synchronizer.** `btn` passes through 2 flops to give `btn_s`.
- **Debounce.**
  - If `btn_s` equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the increment would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - `press` = debounced rising edge, exactly one cycle wide. Release edges produce nothing.
- **FSM.** It acts only on `press`. With no press, all registers hold.
  - LOAD_A + press → LOAD_B. Same edge: `a_out` ← `sw`.
  - LOAD_B + press → SHOW. Same edge: `b_out` ← `sw`.
  - SHOW + press → LOAD_A. Same edge: `result_valid` ← 0. `a_out`, `b_out` and `result` hold their old values until overwritten.
- **Result capture.** `result` ← `sum_in` on the first edge after entering SHOW, i.e. while `state`=SHOW and `result_valid`=0. On that same edge `result_valid` ← 1.
- **Press during the capture cycle.** If a press arrives on the capture edge, capture still happens, the state goes to LOAD_A, and `result_valid` ends up 0, because the press clear wins.
- **Arithmetic.** This block does none. Width is 5 bits, so 15+15=30 fits and there is no truncation.

## Timing
- Take `btn` as first sampled high at edge k and held high thereafter:
  - `btn_s` is high after edge k+1.
  - The debounced level rises at edge k+1+DEBOUNCE_CYCLES.
  - `press` is high for the following cycle.
  - The FSM transition and operand capture occur at edge k+2+DEBOUNCE_CYCLES.
- **Bounce rejection.** A `btn` high pulse shorter than DEBOUNCE_CYCLES cycles, as seen at `btn_s`, produces no press. Any return of `btn_s` to the debounced level restarts the count.
- **Holding the button.** A button held indefinitely gives exactly one press. A new press needs a debounced release first, which takes DEBOUNCE_CYCLES low cycles.
- **Button held through reset.** This counts as a fresh press DEBOUNCE_CYCLES+2 edges after `rst` deasserts.
- **Switch sampling.** `sw` is sampled only on the transition edge. Switch changes at any other time have no effect.
- **Result latency.** `result_valid` rises exactly 1 cycle after `state` becomes SHOW.

## Test plan
- **Reset values.** DEBOUNCE_CYCLES=4. Hold `rst` for 2 edges with `btn` low. Then: all outputs 0, `state`=0, and no state change for 50 cycles.
- **Full sequence.**
  - `sw`=9, clean press: `a_out`=9, `state`=1.
  - `sw`=12, press: `b_out`=12, `state`=2.
  - `result` = model 21 (0b10101), one cycle later `result_valid`=1, `overflow`=1.
  - Third press: `state`=0, `result_valid`=0.
- **Bounce.** `btn` toggles with high widths of 1, 2 and 3 cycles separated by 1–2 low cycles, then stays high for 10 cycles. Required: exactly one press, with the transition 6 edges after the last rising `btn` sample.
- **Held button and switch isolation.** Hold `btn` for 100 cycles while changing `sw` every cycle. Required: one transition only, and the operand equals `sw` as sampled at edge k+6.
- **Extremes.** A=15, B=15 gives `result`=30, `overflow`=1. A=0, B=0 gives `result`=0, `overflow`=0.
- **Reset mid-operation.** Assert `rst` in LOAD_B with `a_out`=7 and `btn` held high. Required: all outputs return to 0 and `state`=LOAD_A. After `rst` deasserts with `btn` still high, a press registers 6 edges later.

Source files
------------

// File: rtl/adder4_operand_loader.sv
// Operand entry stage for the 4-bit ripple adder: debounces one push-button, captures
// operand A then B from slide switches, and registers the returned 5-bit sum for display.
module adder4_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] sw_i,
  input  logic       btn_i,
  input  logic [4:0] sum_in_i,
  output logic [3:0] a_out_o,
  output logic [3:0] b_out_o,
  output logic [4:0] result_o,
  output logic       result_valid_o,
  output logic       overflow_o,
  output logic [1:0] state_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StShow  = 2'd2
  } state_e;

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic            db_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [4:0] res_q, res_d;
  logic       valid_q, valid_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // One-cycle pulse on the debounced rising edge only.
  assign press = db_q & ~db_prev_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = valid_q;

    if ((state_q == StShow) && !valid_q) begin
      res_d   = sum_in_i;
      valid_d = 1'b1;
    end

    // A press in SHOW clears valid even on the capture edge.
    if (press) begin
      unique case (state_q)
        StLoadA: begin
          state_d = StLoadB;
          a_d     = sw_i;
        end
        StLoadB: begin
          state_d = StShow;
          b_d     = sw_i;
        end
        StShow: begin
          state_d = StLoadA;
          valid_d = 1'b0;
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StLoadA;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign a_out_o        = a_q;
  assign b_out_o        = b_q;
  assign result_o       = res_q;
  assign result_valid_o = valid_q;
  assign overflow_o     = res_q[4] & valid_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_adder4_operand_loader.sv
// Self-checking bench for adder4_operand_loader: table-driven operand sequences with a
// result scoreboard, plus bounce, held-button and mid-sequence reset scenarios.
module tb_adder4_operand_loader;

  localparam int unsigned Db = 4;
  localparam int Lat = Db + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [3:0] sw;
  logic [4:0] sum_in;
  logic [3:0] a_out, b_out;
  logic [4:0] result;
  logic       result_valid, overflow;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
    logic       ovf;
  } vec_t;

  vec_t vecs[5];

  adder4_operand_loader #(.DEBOUNCE_CYCLES(Db)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sw_i          (sw),
    .btn_i         (btn),
    .sum_in_i      (sum_in),
    .a_out_o       (a_out),
    .b_out_o       (b_out),
    .result_o      (result),
    .result_valid_o(result_valid),
    .overflow_o    (overflow),
    .state_o       (state)
  );

  // Behavioural stand-in for the downstream ripple adder.
  assign sum_in = {1'b0, a_out} + {1'b0, b_out};

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges between the first edge that samples the stimulus and the state change.
  task automatic wait_change(output int lat);
    logic [1:0] s0;
    s0  = state;
    lat = -1;
    for (int n = 1; n <= 3 * Lat; n++) begin
      tick();
      if (state != s0) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic press(input logic [3:0] v, input string name);
    int lat;
    sw  = v;
    btn = 1'b1;
    wait_change(lat);
    check({name, " latency"}, lat, Lat);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (Db + 4) tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, " state"}, int'(state), 0);
    check({name, " a_out"}, int'(a_out), 0);
    check({name, " b_out"}, int'(b_out), 0);
    check({name, " result"}, int'(result), 0);
    check({name, " result_valid"}, int'(result_valid), 0);
    check({name, " overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int changes;
    int lat;
    int trans_iter;
    logic [1:0] prev;
    logic [3:0] f6;
    logic [4:0] e;
    logic pat[10];

    vecs[0] = '{a: 4'd9,  b: 4'd12, sum: 5'd21, ovf: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd15, sum: 5'd30, ovf: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  sum: 5'd0,  ovf: 1'b0};
    vecs[3] = '{a: 4'd3,  b: 4'd4,  sum: 5'd7,  ovf: 1'b0};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  sum: 5'd16, ovf: 1'b1};

    rst = 1'b1;
    btn = 1'b0;
    sw  = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    changes = 0;
    repeat (50) begin
      tick();
      if (state != 2'd0) changes++;
    end
    check("idle state changes", changes, 0);

    for (int i = 0; i < 5; i++) begin
      press(vecs[i].a, "press A");
      check("a_out after A", int'(a_out), int'(vecs[i].a));
      check("state after A", int'(state), 1);
      release_btn();
      press(vecs[i].b, "press B");
      exp_q.push_back(vecs[i].sum);
      check("b_out after B", int'(b_out), int'(vecs[i].b));
      check("state after B", int'(state), 2);
      check("valid on SHOW entry", int'(result_valid), 0);
      tick();
      check("valid one cycle later", int'(result_valid), 1);
      e = exp_q.pop_front();
      check("result", int'(result), int'(e));
      check("overflow", int'(overflow), int'(vecs[i].ovf));
      release_btn();
      check("valid held in SHOW", int'(result_valid), 1);
      press(4'hF, "press C");
      check("state after C", int'(state), 0);
      check("valid after C", int'(result_valid), 0);
      check("overflow after C", int'(overflow), 0);
      check("result held after C", int'(result), int'(e));
      check("a_out held after C", int'(a_out), int'(vecs[i].a));
      release_btn();
    end

    // Bounce: high widths 1, 2, 3 then a solid press.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    sw = 4'd5;
    changes = 0;
    for (int j = 0; j < 10; j++) begin
      btn = pat[j];
      tick();
      if (state != 2'd0) changes++;
    end
    check("bounce spurious changes", changes, 0);
    btn = 1'b1;
    wait_change(lat);
    check("bounce latency", lat, Lat);
    check("bounce a_out", int'(a_out), 5);
    repeat (3) tick();
    check("bounce single press", int'(state), 1);
    release_btn();

    // Held button with switches changing every cycle.
    btn = 1'b1;
    prev = state;
    changes = 0;
    trans_iter = -1;
    for (int i = 0; i < 100; i++) begin
      sw = 4'((i * 7 + 3) % 16);
      tick();
      if (state != prev) begin
        changes++;
        if (trans_iter < 0) trans_iter = i;
        prev = state;
      end
    end
    f6 = 4'((6 * 7 + 3) % 16);
    exp_q.push_back({1'b0, 4'd5} + {1'b0, f6});
    check("held transitions", changes, 1);
    check("held transition edge", trans_iter, Lat);
    check("held b_out", int'(b_out), int'(f6));
    check("held valid", int'(result_valid), 1);
    e = exp_q.pop_front();
    check("held result", int'(result), int'(e));
    check("held overflow", int'(overflow), int'(e[4]));
    release_btn();
    press(4'd0, "leave SHOW");
    release_btn();

    // Reset in LOAD_B with the button held.
    press(4'd7, "press A7");
    check("a_out before reset", int'(a_out), 7);
    check("state before reset", int'(state), 1);
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("mid reset");
    sw  = 4'hA;
    rst = 1'b0;
    wait_change(lat);
    check("post-reset latency", lat, Lat);
    check("post-reset state", int'(state), 1);
    check("post-reset a_out", int'(a_out), 10);
    release_btn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
